// File: rtl/add_round_key_seq.sv
// AES AddRoundKey engine: a bank of round keys, applied to a 128-bit block
// LANE_W bits per cycle, behind valid/ready handshakes on both sides.
module add_round_key_seq #(
  parameter int LANE_W = 32,
  parameter int NUM_RK = 11,
  localparam int BEATS = 128 / LANE_W,
  localparam int IDX_W = (NUM_RK > 1) ? $clog2(NUM_RK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_we,
  input  logic [IDX_W-1:0] key_idx,
  input  logic [0:127]     key_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:127]     in_data,
  input  logic [IDX_W-1:0] in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:127]     out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [IDX_W:0]   NRK       = (IDX_W + 1)'(NUM_RK);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XOR  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] beat;
  logic [0:127]     work;
  logic [0:127]     snap;
  logic             err;
  logic [0:127]     bank [NUM_RK];

  logic             rd_ok;
  logic             wr_ok;
  logic [0:127]     rd_key;

  always_comb begin
    rd_ok  = {1'b0, in_round} < NRK;
    wr_ok  = {1'b0, key_idx} < NRK;
    rd_key = '0;
    if (rd_ok) rd_key = bank[in_round];
  end

  // The key is copied at acceptance, so later bank writes never reach an
  // in-flight block; a same-edge write is seen only by later blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      beat  <= '0;
      work  <= '0;
      snap  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            snap  <= rd_key;
            err   <= ~rd_ok;
            beat  <= '0;
            state <= S_XOR;
          end
        end
        S_XOR: begin
          work[int'(beat) * LANE_W +: LANE_W] <=
            work[int'(beat) * LANE_W +: LANE_W] ^ snap[int'(beat) * LANE_W +: LANE_W];
          beat <= beat + CNT_W'(1);
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_RK; i++) bank[i] <= '0;
    end else if (key_we && wr_ok) begin
      bank[key_idx] <= key_data;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign out_data  = work;
  assign out_err   = err;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Bench for add_round_key_seq: three lane widths driven in lockstep, checked
// every cycle against a block-level model plus hand-computed vectors.
module tb_add_round_key_seq;

  localparam int NRK = 11;
  localparam int IW  = 4;

  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R0 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] NOTD0 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] D1 = 128'hdeadbeef0123456789abcdefcafef00d;
  localparam logic [127:0] P1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] Q1 = 128'h55aa55aa33cc33cc0ff00ff012345678;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_we = 1'b0;
  logic [IW-1:0] key_idx = '0;
  logic [0:127] key_data = '0;
  logic in_valid = 1'b0;
  logic [0:127] in_data = '0;
  logic [IW-1:0] in_round = '0;
  logic out_ready = 1'b0;

  logic ir [3];
  logic ov [3];
  logic oe [3];
  logic bz [3];
  logic [0:127] od [3];

  int total = 0;
  int bad = 0;

  int lanes [3] = '{32, 8, 128};
  int lat_lit [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  add_round_key_seq #(.LANE_W(32), .NUM_RK(NRK)) u32 (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx), .key_data(key_data),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_round(in_round),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_err(oe[0]), .busy(bz[0]));

  add_round_key_seq #(.LANE_W(8), .NUM_RK(NRK)) u8 (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx), .key_data(key_data),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_round(in_round),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_err(oe[1]), .busy(bz[1]));

  add_round_key_seq #(.LANE_W(128), .NUM_RK(NRK)) u128 (
    .clk(clk), .rst_n(rst_n), .key_we(key_we), .key_idx(key_idx), .key_data(key_data),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .in_round(in_round),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_err(oe[2]), .busy(bz[2]));

  // Block-level model: 0 = waiting for a block, 1 = computing, 2 = result offered.
  int mst [3] = '{0, 0, 0};
  int mcnt [3] = '{0, 0, 0};
  logic [0:127] mexp [3];
  logic merr [3];
  logic [0:127] mbank [16];

  always @(posedge clk or negedge rst_n) begin
    logic [0:127] k;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mst[i] = 0;
        mcnt[i] = 0;
      end
      for (int j = 0; j < 16; j++) mbank[j] = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mst[i] == 0) begin
          if (in_valid) begin
            k = (int'(in_round) < NRK) ? mbank[in_round] : '0;
            mexp[i] = in_data ^ k;
            merr[i] = (int'(in_round) >= NRK);
            mcnt[i] = 0;
            mst[i] = 1;
          end
        end else if (mst[i] == 1) begin
          mcnt[i] = mcnt[i] + 1;
          if (mcnt[i] == 128 / lanes[i]) mst[i] = 2;
        end else if (out_ready) begin
          mst[i] = 0;
        end
      end
      if (key_we && int'(key_idx) < NRK) mbank[key_idx] = key_data;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(input string nm, input int i, input logic [2:0] want);
    total++;
    if ({ir[i], ov[i], bz[i]} !== want) begin
      bad++;
      $display("FAIL %s[%0d] ir/ov/busy got=%b%b%b want=%b", nm, i, ir[i], ov[i], bz[i], want);
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 3; i++) begin
      chk_ctl("model_ctl", i, {mst[i] == 0, mst[i] == 2, mst[i] != 0});
      if (mst[i] == 2) begin
        chk($sformatf("model_data[%0d]", i), od[i], mexp[i]);
        chk($sformatf("model_err[%0d]", i), {127'b0, oe[i]}, {127'b0, merr[i]});
      end
    end
  endtask

  // One clock: model comparison at the falling edge, then inputs may change
  // shortly after the next rising edge.
  task automatic step();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!(ov[0] && ov[1] && ov[2]) && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL wait_valid got=timeout want=out_valid within 40 cycles");
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input int r);
    in_data = d;
    in_round = IW'(r);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk_ctl("reset_ctl", i, 3'b100);
      chk($sformatf("reset_data[%0d]", i), od[i], '0);
      chk($sformatf("reset_err[%0d]", i), {127'b0, oe[i]}, '0);
    end
    rst_n = 1'b1;

    key_we = 1'b1; key_idx = 4'd0; key_data = K0;
    step();
    key_idx = 4'd12; key_data = '1;
    step();
    key_we = 1'b0;

    // Reference vector: latency per lane width and the known result.
    send(D0, 0);
    for (int n = 1; n <= 16; n++) begin
      step();
      for (int i = 0; i < 3; i++)
        chk_ctl($sformatf("latency_n%0d", n), i, {1'b0, n >= lat_lit[i], 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("vec_data[%0d]", i), od[i], R0);
      chk($sformatf("vec_err[%0d]", i), {127'b0, oe[i]}, '0);
    end

    // Back-pressure: result held and new block refused until after handshake.
    in_data = D1; in_round = 4'd0; in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        chk_ctl("hold_ctl", i, 3'b011);
        chk($sformatf("hold_data[%0d]", i), od[i], R0);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) chk_ctl("after_hs", i, 3'b100);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) chk_ctl("accept_after_hs", i, 3'b001);
    wait_valid();
    handshake();

    // Key rewrite while a block is in flight.
    send(D0, 0);
    key_we = 1'b1; key_idx = 4'd0; key_data = '1;
    step();
    key_we = 1'b0;
    wait_valid();
    for (int i = 0; i < 3; i++) chk($sformatf("snap_old[%0d]", i), od[i], R0);
    handshake();
    send(D0, 0);
    wait_valid();
    for (int i = 0; i < 3; i++) chk($sformatf("snap_new[%0d]", i), od[i], NOTD0);
    handshake();

    // Same-edge key write and acceptance on the same index.
    key_we = 1'b1; key_idx = 4'd1; key_data = P1;
    step();
    key_data = Q1;
    send(D1, 1);
    key_we = 1'b0;
    wait_valid();
    chk("same_edge_old", od[0], D1 ^ P1);
    handshake();
    send(D1, 1);
    wait_valid();
    chk("same_edge_new", od[2], D1 ^ Q1);
    handshake();

    // Out-of-range round index.
    send(D0, NRK);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("badidx_data[%0d]", i), od[i], D0);
      chk($sformatf("badidx_err[%0d]", i), {127'b0, oe[i]}, 128'd1);
    end
    handshake();
    send(D1, 15);
    wait_valid();
    handshake();

    // Streaming with the sink always ready.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      in_data = {4{32'(n) * 32'h9e3779b9}};
      in_round = IW'(n % 13);
      step();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 24; n++) step();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a block.
    send(D1, 0);
    step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk_ctl("midreset_ctl", i, 3'b100);
    step();
    step();
    rst_n = 1'b1;
    send(D0, 0);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_reset_data[%0d]", i), od[i], D0);
      chk($sformatf("post_reset_err[%0d]", i), {127'b0, oe[i]}, '0);
    end
    handshake();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
